interval_scheduler: RTL and testbench

Round-robin controller that shares a single up/down interval counter among NREQ requesters. Each requester asks for a timed interval of LEN steps in a chosen direction. The block arbitrates, preloads the shared counter and steps it. It reports completion with a one-cycle DONE pulse tagged with the requester index. It sits in front of the counter datapath and is the only agent that loads or clocks it.

---
 rtl/interval_scheduler.sv | 103 ++++++++++
 tb/tb_interval_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/interval_scheduler.sv
// interval_scheduler: round-robin owner of one shared up/down interval counter
//   CLK, RESET            clock, synchronous active-high reset
//   REQ, REQ_LEN, REQ_DIR per-requester level request, length lane, direction (1 = up)
//   GNT, BUSY             one-hot grant held for the whole job, any-grant flag
//   COUNT                 shared counter value
//   DONE, DONE_ID         one-cycle completion pulse and the completing requester
module interval_scheduler #(
   parameter int WIDTH = 5,
   parameter int NREQ = 4
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [NREQ-1:0]           REQ,
   input  logic [NREQ*WIDTH-1:0]     REQ_LEN,
   input  logic [NREQ-1:0]           REQ_DIR,
   output logic [NREQ-1:0]           GNT,
   output logic                      BUSY,
   output logic [WIDTH-1:0]          COUNT,
   output logic                      DONE,
   output logic [$clog2(NREQ)-1:0]   DONE_ID
);
   localparam int IW = $clog2(NREQ);
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t state, state_n;
   logic [IW-1:0] id, id_n, pick, done_id_n;
   logic [WIDTH-1:0] len, len_n, len_sel, count_n, term;
   logic [NREQ-1:0] gnt_n;
   logic dir, dir_n, dir_sel, done_n;
   assign BUSY = |GNT;
   // id doubles as the round-robin pointer: it always names the last granted requester
   assign term = dir ? len : ~len;
   // pass 1 keeps the lowest active index overall, pass 0 overrides it with the
   // lowest active index above the pointer, which gives the wrap-around scan
   always_comb begin
      pick = '0;
      len_sel = '0;
      dir_sel = 1'b0;
      for (int p = 1; p >= 0; p--)
         for (int i = NREQ - 1; i >= 0; i--)
            if (REQ[i] && (p == 1 || IW'(i) > id)) begin
               pick = IW'(i);
               len_sel = REQ_LEN[i*WIDTH +: WIDTH];
               dir_sel = REQ_DIR[i];
            end
   end
   always_comb begin
      state_n = state;
      gnt_n = GNT;
      count_n = COUNT;
      done_n = 1'b0;
      done_id_n = DONE_ID;
      id_n = id;
      len_n = len;
      dir_n = dir;
      case (state)
         IDLE:
            if (|REQ) begin
               state_n = RUN;
               id_n = pick;
               len_n = len_sel;
               dir_n = dir_sel;
               gnt_n = NREQ'(1) << pick;
               count_n = dir_sel ? '0 : '1;
            end
         RUN:
            if (!REQ[id]) begin
               state_n = IDLE;
               gnt_n = '0;
            end else if (COUNT == term) begin
               state_n = FIN;
               done_n = 1'b1;
               done_id_n = id;
            end else
               count_n = dir ? COUNT + 1'b1 : COUNT - 1'b1;
         FIN: begin
            state_n = IDLE;
            gnt_n = '0;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
         GNT <= '0;
         COUNT <= '0;
         DONE <= 1'b0;
         DONE_ID <= '0;
         id <= IW'(NREQ - 1);
         len <= '0;
         dir <= 1'b0;
      end else begin
         state <= state_n;
         GNT <= gnt_n;
         COUNT <= count_n;
         DONE <= done_n;
         DONE_ID <= done_id_n;
         id <= id_n;
         len <= len_n;
         dir <= dir_n;
      end
   end
endmodule

// File: tb/tb_interval_scheduler.sv
// tb_interval_scheduler: vector table, hand sequences and random traffic against a job-level model
module tb_interval_scheduler;
   localparam int W = 5;
   localparam int N = 4;
   logic CLK = 1'b0;
   logic RESET = 1'b1;
   logic [N-1:0] REQ = '1;
   logic [N*W-1:0] REQ_LEN = '0;
   logic [N-1:0] REQ_DIR = '0;
   logic [N-1:0] GNT;
   logic BUSY;
   logic [W-1:0] COUNT;
   logic DONE;
   logic [1:0] DONE_ID;
   int errors = 0;
   int checks = 0;

   interval_scheduler #(.WIDTH(W), .NREQ(N)) dut (
      .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_LEN(REQ_LEN), .REQ_DIR(REQ_DIR),
      .GNT(GNT), .BUSY(BUSY), .COUNT(COUNT), .DONE(DONE), .DONE_ID(DONE_ID)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Job-level reference: a job is (owner, length, direction, steps taken);
   // the expected counter is start value plus/minus the steps taken.
   bit m_busy = 0, m_fin = 0, m_done = 0, m_dir = 0;
   int m_id = 0, m_last = N - 1, m_len = 0, m_t = 0, m_count = 0, m_did = 0, m_c = 0;
   always @(posedge CLK) begin
      m_done = 0;
      if (RESET) begin
         m_busy = 0; m_fin = 0; m_count = 0; m_did = 0; m_last = N - 1;
      end else if (!m_busy) begin
         if (REQ != 0) begin
            for (int k = 1; k <= N; k++) begin
               m_c = (m_last + k) % N;
               if (REQ[m_c]) begin
                  m_id = m_c;
                  break;
               end
            end
            m_last = m_id;
            m_busy = 1; m_fin = 0; m_t = 0;
            m_len = int'(REQ_LEN[m_id*W +: W]);
            m_dir = REQ_DIR[m_id];
            m_count = m_dir ? 0 : (1 << W) - 1;
         end
      end else if (m_fin) m_busy = 0;
      else if (!REQ[m_id]) m_busy = 0;
      else if (m_t == m_len) begin
         m_fin = 1; m_done = 1; m_did = m_id;
      end else begin
         m_t++;
         m_count = m_dir ? m_t : (1 << W) - 1 - m_t;
      end
      #1;
      chk("model_gnt", int'(GNT), m_busy ? (1 << m_id) : 0);
      chk("model_busy", int'(BUSY), int'(m_busy));
      chk("model_count", int'(COUNT), m_count);
      chk("model_done", int'(DONE), int'(m_done));
      chk("model_done_id", int'(DONE_ID), m_did);
   end

   function automatic int oh2i(input logic [N-1:0] oh);
      for (int i = 0; i < N; i++) if (oh[i]) return i;
      return -1;
   endfunction

   task automatic wait_idle();
      int n = 0;
      @(negedge CLK);
      while (BUSY && n < 100) begin
         @(negedge CLK);
         n++;
      end
      chk("idle_timeout", int'(BUSY), 0);
   endtask

   typedef struct {
      logic [N-1:0] req;
      int len;
      bit dir;
      logic [N-1:0] gnt;
      int start;
      int fin;
      int id;
      int occ;
   } vec_t;
   vec_t tbl[6];

   task automatic run_vec(input vec_t v, input int idx);
      int occ = 0, start = -1, fin = -1, did = -1;
      logic [N-1:0] first = '0;
      wait_idle();
      for (int i = 0; i < N; i++)
         if (v.req[i]) begin
            REQ_LEN[i*W +: W] = W'(v.len);
            REQ_DIR[i] = v.dir;
         end
      REQ = v.req;
      for (int n = 0; n < 80; n++) begin
         @(negedge CLK);
         if (GNT != 0) begin
            if (occ == 0) begin
               first = GNT;
               start = int'(COUNT);
            end
            occ++;
         end else if (occ > 0) break;
         if (DONE) begin
            fin = int'(COUNT);
            did = int'(DONE_ID);
            REQ = '0;
         end
      end
      REQ = '0;
      chk($sformatf("vec%0d_gnt", idx), int'(first), int'(v.gnt));
      chk($sformatf("vec%0d_start", idx), start, v.start);
      chk($sformatf("vec%0d_fin_count", idx), fin, v.fin);
      chk($sformatf("vec%0d_done_id", idx), did, v.id);
      chk($sformatf("vec%0d_occupancy", idx), occ, v.occ);
   endtask

   int gseq[$], gcyc[$], dseq[$];
   logic [N-1:0] prev, raise;
   bit done_seen;
   int n;

   initial begin
      tbl[0] = '{4'b0100, 3, 1'b1, 4'b0100, 0, 3, 2, 5};
      tbl[1] = '{4'b0001, 2, 1'b0, 4'b0001, 31, 29, 0, 4};
      tbl[2] = '{4'b0001, 0, 1'b0, 4'b0001, 31, 31, 0, 2};
      tbl[3] = '{4'b1000, 31, 1'b1, 4'b1000, 0, 31, 3, 33};
      tbl[4] = '{4'b0010, 31, 1'b0, 4'b0010, 31, 0, 1, 33};
      tbl[5] = '{4'b0010, 0, 1'b1, 4'b0010, 0, 0, 1, 2};

      // reset held two cycles with every requester asking
      repeat (2) begin
         @(negedge CLK);
         chk("rst_gnt", int'(GNT), 0);
         chk("rst_busy", int'(BUSY), 0);
         chk("rst_done", int'(DONE), 0);
         chk("rst_count", int'(COUNT), 0);
      end
      RESET = 1'b0;
      @(negedge CLK);
      chk("rst_first_grant", int'(GNT), 1);
      REQ = '0;
      wait_idle();

      foreach (tbl[i]) run_vec(tbl[i], i);

      // round robin: everyone asks, drops on own DONE, re-raises a cycle later
      RESET = 1'b1;
      REQ = '0;
      @(negedge CLK);
      for (int i = 0; i < N; i++) begin
         REQ_LEN[i*W +: W] = W'(1);
         REQ_DIR[i] = 1'b1;
      end
      RESET = 1'b0;
      REQ = '1;
      prev = '0;
      raise = '0;
      for (int c = 1; c <= 24; c++) begin
         @(negedge CLK);
         REQ = REQ | raise;
         raise = '0;
         if (GNT != 0 && prev == 0) begin
            gseq.push_back(oh2i(GNT));
            gcyc.push_back(c);
         end
         prev = GNT;
         if (DONE) begin
            dseq.push_back(int'(DONE_ID));
            REQ[DONE_ID] = 1'b0;
            raise[DONE_ID] = 1'b1;
         end
      end
      chk("rr_grant_count", gseq.size() >= 5 ? 5 : gseq.size(), 5);
      chk("rr_done_count", dseq.size() >= 5 ? 5 : dseq.size(), 5);
      for (int i = 0; i < 5 && i < gseq.size(); i++) chk($sformatf("rr_grant%0d", i), gseq[i], i % N);
      for (int i = 0; i < 5 && i < dseq.size(); i++) chk($sformatf("rr_done%0d", i), dseq[i], i % N);
      for (int i = 1; i < 5 && i < gcyc.size(); i++) chk($sformatf("rr_spacing%0d", i), gcyc[i] - gcyc[i-1], 4);
      REQ = '0;
      wait_idle();

      // abort: requester 1 drops while counting, requester 3 waiting
      REQ_LEN[1*W +: W] = W'(10);
      REQ_DIR[1] = 1'b1;
      REQ_LEN[3*W +: W] = W'(2);
      REQ_DIR[3] = 1'b1;
      REQ = 4'b0010;
      done_seen = 0;
      n = 0;
      while (!(GNT == 4'b0010 && COUNT == 4) && n < 40) begin
         @(negedge CLK);
         done_seen |= DONE;
         n++;
      end
      chk("abort_reach_4", int'(COUNT), 4);
      REQ[3] = 1'b1;
      @(negedge CLK);
      done_seen |= DONE;
      REQ[1] = 1'b0;
      @(negedge CLK);
      done_seen |= DONE;
      chk("abort_gnt", int'(GNT), 0);
      chk("abort_busy", int'(BUSY), 0);
      chk("abort_count", int'(COUNT), 5);
      chk("abort_no_done", int'(done_seen), 0);
      @(negedge CLK);
      chk("abort_next_grant", int'(GNT), 8);
      REQ = '0;
      wait_idle();

      // reset in the middle of a job
      REQ_LEN[3*W +: W] = W'(10);
      REQ = 4'b1010;
      n = 0;
      while (!(BUSY && COUNT == 6) && n < 40) begin
         @(negedge CLK);
         n++;
      end
      chk("midrst_reach_6", int'(COUNT), 6);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      chk("midrst_gnt", int'(GNT), 0);
      chk("midrst_busy", int'(BUSY), 0);
      chk("midrst_done", int'(DONE), 0);
      chk("midrst_count", int'(COUNT), 0);
      chk("midrst_done_id", int'(DONE_ID), 0);
      @(negedge CLK);
      chk("midrst_first_grant", int'(GNT), 2);
      REQ = '0;
      wait_idle();

      // random traffic, including length/direction churn after grant and rare resets
      for (int c = 0; c < 1500; c++) begin
         @(negedge CLK);
         if ($urandom_range(0, 7) == 0) REQ = N'($urandom);
         if (DONE && $urandom_range(0, 1) == 1) REQ[DONE_ID] = 1'b0;
         for (int i = 0; i < N; i++)
            REQ_LEN[i*W +: W] = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
         REQ_DIR = N'($urandom);
         RESET = ($urandom_range(0, 199) == 0);
      end
      RESET = 1'b0;
      REQ = '0;
      wait_idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
